topic_bias_injector: RTL
========================

// Module: topic_bias_injector
// PURPOSE
//   Read side of the topic-memory path. The topic result (winner/strength/valid) settles one cycle after delta_tick.
//   This block samples it in that cycle and turns it into a long-term score bias on the topic pair.
//   The bias decays by a fixed step on every theta_tick until the next delta_tick reloads it.
//   Sits between the per-gamma score stage and the winner-take-all stage: 6 pair scores in, biased scores out.
// PARAMETERS
//   SCORE_W     8      width of one pair score (unsigned)
//   BIAS_W      4      width of bias_level
//   BIAS_GAIN   2      bias_level loaded = topic_strength * BIAS_GAIN, capped at BIAS_MAX
//   BIAS_MAX    15     bias cap, must be <= 2**BIAS_W-1
//   DECAY_STEP  2      bias_level decrement per theta_tick, saturating at 0
//   STAB_THR    3      minimum topic_strength that arms the bias
// PORTS
//   clk             in   1          single clock, all logic on posedge
//   rst             in   1          synchronous reset, active-high
//   theta_tick      in   1          1-cycle pulse, theta boundary
//   delta_tick      in   1          1-cycle pulse, delta boundary
//   topic_winner    in   3          topic pair index (0..5 legal)
//   topic_strength  in   3          votes of topic winner (0..7)
//   topic_valid     in   1          topic result valid
//   score_in_valid  in   1          score vector valid this cycle
//   score_in        in   6*SCORE_W  packed pair scores, pair p at [p*SCORE_W +: SCORE_W]
//   score_out_valid out  1          score_in_valid delayed 1 cycle
//   score_out       out  6*SCORE_W  biased scores, same packing
//   bias_pair       out  3          pair currently receiving bias
//   bias_level      out  BIAS_W     current bias magnitude
//   bias_active     out  1          1 when state==ACTIVE
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE; all outputs 0. Reset mid-ACTIVE drops the bias the next cycle.
//     Reset also drops an in-flight score vector: score_out_valid=0.
//   FSM states: IDLE, LATCH, ACTIVE. delta_tick has priority over theta_tick in every state.
//   IDLE:   delta_tick -> LATCH; theta_tick ignored.
//   LATCH:  lasts exactly 1 cycle; samples topic_*.
//     Arm condition: topic_valid=1, strength>=STAB_THR and winner<=5.
//       Armed: bias_pair=winner; bias_level=min(strength*BIAS_GAIN, BIAS_MAX); -> ACTIVE.
//       Not armed: bias_level=0; bias_pair unchanged; -> IDLE.
//     The product is computed at 3+clog2(BIAS_GAIN+1) bits before the cap; no truncation wrap.
//     A delta_tick arriving in LATCH is ignored (ticks are never adjacent).
//   ACTIVE: delta_tick -> LATCH; bias_level holds its value during LATCH.
//     theta_tick alone: bias_level -= DECAY_STEP, floor 0.
//       If the result is 0 -> IDLE, and bias_active falls in the same cycle bias_level reaches 0.
//     theta_tick together with delta_tick: no decrement; reload path wins.
//   Score path: fixed 1-cycle latency, independent of FSM; never stalls.
//     score_out[p] = sat(score_in[p] + (bias_active && p==bias_pair ? bias_level : 0)).
//     sat clamps at 2**SCORE_W-1. The add uses bias_active/bias_level registered values of the same cycle.
//     score_out holds its last value when score_in_valid=0; only score_out_valid deasserts.
//   Bias never applies to pairs 6/7; no score is ever decreased.
// TESTING
//   (Defaults throughout.)
//   1 Pass-through: reset, then score_in pair0=10, pair5=200, valid=1.
//     -> next cycle score_out_valid=1, pair0=10, pair5=200, bias_active=0.
//   2 Arm: delta_tick, then winner=2/strength=5/valid=1 in the next cycle.
//     -> following cycle bias_active=1, bias_pair=2, bias_level=10.
//     -> score pair2=100 gives 110; pair1=100 gives 100.
//   3 Decay: from test 2, 4 theta_ticks -> level 8,6,4,2; 5th theta_tick -> level 0, bias_active=0, state IDLE.
//   4 Saturation/cap: strength=7 -> level 14 (cap not hit); with BIAS_GAIN=3 -> level 15.
//     -> score pair2=250 gives score_out 255.
//   5 Reject: strength=2 -> inactive; winner=6, strength=7 -> inactive; topic_valid=0 -> inactive.
//     -> all three leave bias_level=0.
//   6 Collision/reset: in ACTIVE level=10, theta_tick+delta_tick same cycle -> no decrement, reload path taken.
//     Then rst asserted mid-ACTIVE -> next cycle all outputs 0.

Source files
------------

// File: rtl/topic_bias_injector.sv
// Turns the settled topic result into a decaying score bias on one pair and
// adds that bias to the 6-pair score vector with a fixed 1-cycle latency.
module topic_bias_injector #(
    parameter int SCORE_W    = 8,
    parameter int BIAS_W     = 4,
    parameter int BIAS_GAIN  = 2,
    parameter int BIAS_MAX   = 15,
    parameter int DECAY_STEP = 2,
    parameter int STAB_THR   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 theta_tick,
    input  logic                 delta_tick,
    input  logic [2:0]           topic_winner,
    input  logic [2:0]           topic_strength,
    input  logic                 topic_valid,
    input  logic                 score_in_valid,
    input  logic [6*SCORE_W-1:0] score_in,
    output logic                 score_out_valid,
    output logic [6*SCORE_W-1:0] score_out,
    output logic [2:0]           bias_pair,
    output logic [BIAS_W-1:0]    bias_level,
    output logic                 bias_active,
    output logic [1:0]           fsm_state
);

    // Valid-only stream: score_in_valid qualifies score_in in the same cycle,
    // there is no ready; the path never stalls and score_out_valid follows 1 cycle later.

    localparam int PROD_W = 3 + $clog2(BIAS_GAIN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LATCH  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [2:0]          pair_nxt;
    logic [BIAS_W-1:0]   level_nxt;
    logic [PROD_W-1:0]   prod;
    logic [BIAS_W-1:0]   level_load;
    logic [BIAS_W-1:0]   level_dec;
    logic                armed;
    logic [6*SCORE_W-1:0] biased;
    logic [SCORE_W:0]    sum;

    // Product is wide enough that strength*gain never wraps before the cap.
    assign prod       = PROD_W'(topic_strength) * PROD_W'(BIAS_GAIN);
    assign level_load = (int'(prod) > BIAS_MAX) ? BIAS_W'(BIAS_MAX) : BIAS_W'(prod);
    assign level_dec  = (int'(bias_level) > DECAY_STEP) ? bias_level - BIAS_W'(DECAY_STEP) : '0;
    assign armed      = topic_valid && (int'(topic_strength) >= STAB_THR) && (topic_winner <= 3'd5);

    assign bias_active = (state == ACTIVE);
    assign fsm_state   = state;

    always_comb begin
        state_nxt = state;
        pair_nxt  = bias_pair;
        level_nxt = bias_level;
        case (state)
            IDLE: begin
                if (delta_tick) state_nxt = LATCH;
            end
            LATCH: begin
                if (armed) begin
                    state_nxt = ACTIVE;
                    pair_nxt  = topic_winner;
                    level_nxt = level_load;
                end else begin
                    state_nxt = IDLE;
                    level_nxt = '0;
                end
            end
            ACTIVE: begin
                // delta_tick wins over a coincident theta_tick: reload, no decay
                if (delta_tick) begin
                    state_nxt = LATCH;
                end else if (theta_tick) begin
                    level_nxt = level_dec;
                    if (level_dec == '0) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bias_pair  <= '0;
            bias_level <= '0;
        end else begin
            state      <= state_nxt;
            bias_pair  <= pair_nxt;
            bias_level <= level_nxt;
        end
    end

    always_comb begin
        biased = '0;
        sum    = '0;
        for (int p = 0; p < 6; p++) begin
            sum = {1'b0, score_in[p*SCORE_W +: SCORE_W]};
            if (bias_active && (bias_pair == 3'(p)))
                sum = sum + (SCORE_W+1)'(bias_level);
            biased[p*SCORE_W +: SCORE_W] = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_out_valid <= 1'b0;
            score_out       <= '0;
        end else begin
            score_out_valid <= score_in_valid;
            if (score_in_valid) score_out <= biased;
        end
    end

endmodule
